// File: rtl/imm_split.sv
// imm_split: breaks a 2*IMM_W-bit constant into the LUI/ORI immediate pair.
// The upper beat is always emitted. The lower beat is skipped when
// SKIP_ZERO_LO is set and the lower half is zero, because the LUI
// zero-fill already produces those bits.
// All outputs are decoded only from the registered state and the held word,
// so they stay stable under backpressure.
module imm_split #(
    parameter int IMM_W        = 8,
    parameter bit SKIP_ZERO_LO = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*IMM_W-1:0] in_word,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IMM_W-1:0]   out_imm,
    output logic               out_is_lo,
    output logic               out_last,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT_HI = 2'd1,
        EMIT_LO = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [2*IMM_W-1:0]   word_q;
    logic [2*IMM_W-1:0]   word_d;
    logic                 lo_zero_s;
    logic                 hi_last_s;

    // The upper beat is final when the lower half can be dropped.
    assign lo_zero_s = (word_q[IMM_W-1:0] == {IMM_W{1'b0}});
    assign hi_last_s = SKIP_ZERO_LO && lo_zero_s;

    // Next-state and word-capture logic; the word is sampled only from IDLE.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_word;
                    state_d = EMIT_HI;
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT_HI: begin
                if (out_ready) begin
                    if (hi_last_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = EMIT_LO;
                    end
                end else begin
                    state_d = EMIT_HI;
                end
            end
            EMIT_LO: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = EMIT_LO;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the registered state and held word only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_imm   = {IMM_W{1'b0}};
        out_is_lo = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            EMIT_HI: begin
                out_valid = 1'b1;
                out_imm   = word_q[2*IMM_W-1:IMM_W];
                out_is_lo = 1'b0;
                out_last  = hi_last_s;
            end
            EMIT_LO: begin
                out_valid = 1'b1;
                out_imm   = word_q[IMM_W-1:0];
                out_is_lo = 1'b1;
                out_last  = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // State and word registers. A synchronous reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= {(2*IMM_W){1'b0}};
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

endmodule
